// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle RV32I-subset datapath (R-type, I-ALU, load,
// store, conditional branch). Each instruction walks FETCH -> DECODE and then
// a class-specific path; unknown opcodes, unsupported branch conditions and
// memory accesses that never complete land in a sticky ERROR state.
//
// Ports
//   clk          sole clock, rising-edge
//   reset_n      asynchronous active-low reset
//   instruction  IR contents (valid from DECODE onward)
//   mem_ready    completion strobe for the current memory access
//   alu_zero     ALU result is zero
//   alu_lt       signed rs1 < rs2
//   ALUOp        00 add, 01 branch compare, 10 funct-decoded
//   alu_src_a    0 PC, 1 rs1
//   alu_src_b    00 rs2, 01 const 4, 10 I/S immediate, 11 branch immediate
//   ir_write, pc_write, pc_src, iord, mem_read, mem_write,
//   reg_write, mem_to_reg, illegal   single-bit control strobes
//   state        current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic [1:0]  ALUOp,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [2:0]  state
);

  localparam int            CW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  state_t        cur_state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          waiting;
  logic          timed_out;
  logic          branch_valid;
  logic          branch_taken;
  logic          unused_instr_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign state  = cur_state;

  // Only opcode and funct3 steer control; the remaining IR fields feed the
  // datapath directly.
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  // A memory wait is only meaningful in FETCH and MEM; mem_ready is ignored
  // elsewhere. The timeout fires on the last allowed idle cycle so that a
  // late mem_ready on that same cycle still wins.
  assign waiting   = ((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ready;
  assign timed_out = waiting && (wait_cnt == LAST_WAIT);

  // Branch condition from funct3; unsupported encodings are flagged invalid.
  always_comb begin
    branch_valid = 1'b1;
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = alu_zero;
      3'b001:  branch_taken = !alu_zero;
      3'b100:  branch_taken = alu_lt;
      3'b101:  branch_taken = !alu_lt;
      default: branch_valid = 1'b0;
    endcase
  end

  // State register and wait counter. The counter is zero whenever the FSM is
  // not idling on memory, so it is already clear on entry to FETCH or MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= waiting ? wait_cnt + 1'b1 : '0;
    end
  end

  // Next-state and output decode. Reset forces every output low so that no
  // memory or register strobe escapes while reset_n is held.
  always_comb begin
    next_state = cur_state;
    ALUOp      = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_ERROR;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE: next_state = S_EXEC;
          OP_BRANCH:                     next_state = S_BRANCH;
          default:                       next_state = S_ERROR;
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (opcode)
          OP_R: begin
            ALUOp      = 2'b10;
            next_state = S_WB;
          end
          OP_I: begin
            alu_src_b  = 2'b10;
            ALUOp      = 2'b10;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b  = 2'b10;
            next_state = S_MEM;
          end
          default: next_state = S_ERROR;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        case (opcode)
          OP_LOAD: begin
            mem_read = 1'b1;
            if (mem_ready) next_state = S_WB;
          end
          OP_STORE: begin
            mem_write = 1'b1;
            if (mem_ready) next_state = S_FETCH;
          end
          default: next_state = S_ERROR;
        endcase
        if (timed_out) next_state = S_ERROR;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUOp     = 2'b01;
        if (branch_valid) begin
          pc_write   = branch_taken;
          pc_src     = branch_taken;
          next_state = S_FETCH;
        end else begin
          next_state = S_ERROR;
        end
      end
      S_ERROR: begin
        illegal = 1'b1;
      end
      default: next_state = S_ERROR;
    endcase

    if (!reset_n) begin
      ALUOp      = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of cycles to wait for mem_ready in FETCH or MEM before faulting.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 instruction  in  32  current IR contents; valid from DECODE onward.
REQ-005 mem_ready  in  1  memory completion strobe for the current mem_read or mem_write.
REQ-006 alu_zero  in  1  ALU result equals zero.
REQ-007 alu_lt  in  1  signed rs1 < rs2 from the ALU.
REQ-008 ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-009 alu_src_a  out  1  0 = PC, 1 = rs1.
REQ-010 alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = I/S immediate, 11 = branch immediate.
REQ-011 Single-bit strobes, all outputs: ir_write, pc_write, pc_src (1 = branch target), iord (1 = data address), mem_read, mem_write, reg_write, mem_to_reg, illegal.
REQ-012 state  out  3  current FSM state, for debug.

Function
REQ-013 State encodings SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, ERROR=7.
REQ-014 Outputs SHALL be combinational from state, instruction, mem_ready and ALU flags. Any output not listed for a state SHALL be 0.
REQ-015 FETCH:
- Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOp=00.
- When mem_ready=1, also drives ir_write=1, pc_write=1, pc_src=0, then goes to DECODE.
- Otherwise stays in FETCH.
REQ-016 DECODE: drives alu_src_a=0, alu_src_b=11, ALUOp=00 (branch target precompute). Next state by opcode instruction[6:0]:
- 0110011, 0010011, 0000011, 0100011 -> EXEC.
- 1100011 -> BRANCH.
- Any other opcode -> ERROR.
REQ-017 EXEC: drives alu_src_a=1.
- R-type: alu_src_b=00, ALUOp=10, next WB.
- I-ALU: alu_src_b=10, ALUOp=10, next WB.
- Load/store: alu_src_b=10, ALUOp=00, next MEM.
REQ-018 MEM: drives iord=1; mem_read=1 for load, mem_write=1 for store.
- Holds until mem_ready=1.
- Then load -> WB, store -> FETCH.
REQ-019 WB: drives reg_write=1 for exactly one cycle, mem_to_reg=1 for load (else 0), then goes to FETCH.
REQ-020 BRANCH: drives alu_src_a=1, alu_src_b=00, ALUOp=01. Taken condition by funct3 instruction[14:12]:
- 000 -> alu_zero; 001 -> !alu_zero; 100 -> alu_lt; 101 -> !alu_lt.
- Taken: pc_write=1 and pc_src=1 in the same cycle.
- Next state FETCH; any other funct3 -> ERROR with no pc_write.
REQ-021 ERROR: illegal=1 and all strobes 0. State is sticky until reset_n is asserted.
REQ-022 Wait counter: ceil(log2(TIMEOUT))+1 bits.
- Clears on entry to FETCH or MEM; increments each cycle in FETCH/MEM with mem_ready=0.
- When the count reaches TIMEOUT-1 with mem_ready still 0, next state SHALL be ERROR.
- mem_ready=1 on that same cycle wins: normal transition.
REQ-023 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-024 Instruction latency with zero-wait memory: R/I-ALU 4 cycles, load 5, store 4, branch 3.

Reset
REQ-025 While reset_n=0: state=FETCH, wait counter=0, and all strobes including mem_read SHALL be 0, overriding REQ-015.
REQ-026 Reset assertion mid-operation (any state, including MEM with a pending access) SHALL abort immediately. No write strobe is asserted after reset_n falls.
REQ-027 On the first clk edge after reset_n rises, the FSM SHALL be in FETCH with mem_read=1.

Verification
REQ-028 R-type: instruction 0x002081B3, mem_ready=1 in FETCH -> states 0,1,2,4,0; EXEC ALUOp=10, alu_src_b=00; WB reg_write=1, mem_to_reg=0.
REQ-029 Load: 0x0000A103, mem_ready held low 3 cycles in MEM -> MEM lasts 4 cycles with iord=1, mem_read=1; then WB with mem_to_reg=1, reg_write=1.
REQ-030 Branch: 0x00208463 with alu_zero=1 -> BRANCH pc_write=1, pc_src=1; repeat with alu_zero=0 -> pc_write=0; then 0x00209463 (bne) with alu_zero=0 -> taken.
REQ-031 Illegal: instruction 0x0000007F -> DECODE->ERROR, illegal=1, held for 20 cycles with all strobes 0 until reset_n=0.
REQ-032 Timeout: mem_ready=0 forever in FETCH -> ERROR entered after exactly TIMEOUT (16) cycles in FETCH; a variant with mem_ready=1 on cycle 16 -> DECODE.
REQ-033 Reset mid-store: 0x0020A023 in MEM, reset_n=0 -> mem_write drops in the same cycle; after release, state=0 and mem_read=1.
